// File: rtl/button_pkg.sv
//------------------------------------------------------------------------------
// button_pkg
// Shared types and elaboration-time helpers for the pushbutton front end.
//   rpt_state_t  : auto-repeat FSM states (IDLE, HOLD, REPEAT)
//   countWidth() : bits needed to hold a counter value in 0..maxValue
//   maxOf()      : larger of two integers, used to size a shared counter
//------------------------------------------------------------------------------
package button_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,   // button not held (debounced level low)
      HOLD   = 2'd1,   // held, waiting out the initial repeat delay
      REPEAT = 2'd2    // held, issuing repeat ticks at the repeat rate
   } rpt_state_t;

   // Width of a counter that must be able to hold every value 0..maxValue.
   // Never returns less than one bit so degenerate parameters still elaborate.
   function automatic int countWidth(input int maxValue);
      if (maxValue < 1) begin
         return 1;
      end
      return $clog2(maxValue + 1);
   endfunction

   function automatic int maxOf(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/button_channel.sv
//------------------------------------------------------------------------------
// button_channel
// One pushbutton channel: synchroniser chain, counter debouncer and an
// auto-repeat FSM producing single-cycle press / release pulses.
//
// Ports
//   clk        : system clock
//   reset      : synchronous active-high reset
//   btnIn      : raw asynchronous button level (1 = pressed)
//   repeatEn   : auto-repeat enable for this channel (synchronous)
//   btnLevel   : debounced button level (registered)
//   btnPress   : one-cycle pulse on accepted press and on each repeat tick
//   btnRelease : one-cycle pulse on accepted release
//------------------------------------------------------------------------------
module button_channel
   import button_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REPEAT_DELAY    = 8,
   parameter int REPEAT_RATE     = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic btnIn,
   input  logic repeatEn,
   output logic btnLevel,
   output logic btnPress,
   output logic btnRelease
);

   // Debounce counter counts 0..DEBOUNCE_CYCLES-1 before the level flips.
   localparam int DB_W = countWidth(DEBOUNCE_CYCLES);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   // One repeat counter serves both the initial delay and the repeat rate.
   localparam int RPT_W = countWidth(maxOf(REPEAT_DELAY, REPEAT_RATE));
   localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

   //---------------------------------------------------------------------------
   // Synchroniser: plain shift chain, oldest sample is the synchronised bit.
   //---------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] syncReg;
   logic                   syncBit;

   always_ff @(posedge clk) begin
      if (reset) begin
         syncReg <= '0;
      end else begin
         syncReg <= {syncReg[SYNC_STAGES-2:0], btnIn};
      end
   end

   assign syncBit = syncReg[SYNC_STAGES-1];

   //---------------------------------------------------------------------------
   // Debouncer: the level only flips after DEBOUNCE_CYCLES consecutive
   // mismatching samples; any matching sample restarts the count, so a
   // glitch shorter than that never reaches the level.
   //---------------------------------------------------------------------------
   logic [DB_W-1:0] dbCntReg;
   logic [DB_W-1:0] dbCntNext;
   logic            levelReg;
   logic            levelNext;

   always_comb begin
      levelNext = levelReg;
      dbCntNext = '0;
      if (syncBit != levelReg) begin
         if (dbCntReg == DB_LAST) begin
            levelNext = ~levelReg;
         end else begin
            dbCntNext = dbCntReg + DB_W'(1);
         end
      end
   end

   // Edges are taken from the next-state level so the pulses land in the
   // same cycle the registered level changes.
   logic levelRise;
   logic levelFall;

   assign levelRise = levelNext & ~levelReg;
   assign levelFall = ~levelNext & levelReg;

   //---------------------------------------------------------------------------
   // Auto-repeat FSM
   //---------------------------------------------------------------------------
   rpt_state_t       stateReg;
   rpt_state_t       stateNext;
   logic [RPT_W-1:0] rcntReg;
   logic [RPT_W-1:0] rcntNext;
   logic             pressReg;
   logic             pressNext;
   logic             releaseReg;
   logic             releaseNext;

   always_ff @(posedge clk) begin
      if (reset) begin
         dbCntReg   <= '0;
         levelReg   <= 1'b0;
         stateReg   <= IDLE;
         rcntReg    <= '0;
         pressReg   <= 1'b0;
         releaseReg <= 1'b0;
      end else begin
         dbCntReg   <= dbCntNext;
         levelReg   <= levelNext;
         stateReg   <= stateNext;
         rcntReg    <= rcntNext;
         pressReg   <= pressNext;
         releaseReg <= releaseNext;
      end
   end

   always_comb begin
      stateNext   = stateReg;
      rcntNext    = rcntReg;
      pressNext   = 1'b0;
      releaseNext = 1'b0;

      if (levelFall) begin
         // A release overrides any repeat tick that would fall on this cycle.
         releaseNext = 1'b1;
         stateNext   = IDLE;
         rcntNext    = '0;
      end else begin
         unique case (stateReg)
            IDLE: begin
               rcntNext = '0;
               if (levelRise) begin
                  pressNext = 1'b1;
                  stateNext = HOLD;
               end
            end

            HOLD: begin
               if (!repeatEn) begin
                  // Paused: re-enabling restarts the full delay.
                  rcntNext = '0;
               end else if (rcntReg == DELAY_LAST) begin
                  pressNext = 1'b1;
                  rcntNext  = '0;
                  stateNext = REPEAT;
               end else begin
                  rcntNext = rcntReg + RPT_W'(1);
               end
            end

            REPEAT: begin
               if (!repeatEn) begin
                  rcntNext = '0;
               end else if (rcntReg == RATE_LAST) begin
                  pressNext = 1'b1;
                  rcntNext  = '0;
               end else begin
                  rcntNext = rcntReg + RPT_W'(1);
               end
            end

            default: begin
               stateNext = IDLE;
               rcntNext  = '0;
            end
         endcase
      end
   end

   assign btnLevel   = levelReg;
   assign btnPress   = pressReg;
   assign btnRelease = releaseReg;

endmodule

// File: rtl/button_conditioner.sv
//------------------------------------------------------------------------------
// button_conditioner
// N-channel pushbutton front end. Each channel is synchronised, debounced and
// optionally auto-repeated independently; pulses are suitable as clock
// enables for downstream logic on the same clock.
//
// Ports
//   clk         : system clock
//   reset       : synchronous active-high reset
//   btn_in      : raw asynchronous button levels, 1 = pressed   [NUM_BTNS]
//   repeat_en   : per-channel auto-repeat enable                [NUM_BTNS]
//   btn_level   : debounced button levels                       [NUM_BTNS]
//   btn_press   : one-cycle press / repeat-tick pulses          [NUM_BTNS]
//   btn_release : one-cycle release pulses                      [NUM_BTNS]
//   any_press   : OR of btn_press
//------------------------------------------------------------------------------
module button_conditioner
   import button_pkg::*;
#(
   parameter int NUM_BTNS        = 3,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REPEAT_DELAY    = 8,
   parameter int REPEAT_RATE     = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_BTNS-1:0] btn_in,
   input  logic [NUM_BTNS-1:0] repeat_en,
   output logic [NUM_BTNS-1:0] btn_level,
   output logic [NUM_BTNS-1:0] btn_press,
   output logic [NUM_BTNS-1:0] btn_release,
   output logic                any_press
);

   generate
      for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : gChannel
         button_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_RATE     (REPEAT_RATE)
         ) uChannel (
            .clk        (clk),
            .reset      (reset),
            .btnIn      (btn_in[gi]),
            .repeatEn   (repeat_en[gi]),
            .btnLevel   (btn_level[gi]),
            .btnPress   (btn_press[gi]),
            .btnRelease (btn_release[gi])
         );
      end
   endgenerate

   // Pure reduction of flop outputs, so it is as clean as btn_press itself.
   assign any_press = |btn_press;

endmodule

// File: tb/tb_button_conditioner.sv
//------------------------------------------------------------------------------
// tb_button_conditioner
// Directed scenarios followed by randomized stimulus, checked every cycle
// against a behavioural model built from the timing rules: sync delay as a
// sample history, debouncing as a run length of mismatches, repeats as
// elapsed enabled hold time since the previous pulse.
//------------------------------------------------------------------------------
module tb_button_conditioner;

   localparam int NB = 3;
   localparam int SS = 2;
   localparam int DC = 4;
   localparam int RD = 8;
   localparam int RR = 4;

   logic          clk;
   logic          reset;
   logic [NB-1:0] btn_in;
   logic [NB-1:0] repeat_en;
   logic [NB-1:0] btn_level;
   logic [NB-1:0] btn_press;
   logic [NB-1:0] btn_release;
   logic          any_press;

   button_conditioner #(
      .NUM_BTNS        (NB),
      .SYNC_STAGES     (SS),
      .DEBOUNCE_CYCLES (DC),
      .REPEAT_DELAY    (RD),
      .REPEAT_RATE     (RR)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .btn_in      (btn_in),
      .repeat_en   (repeat_en),
      .btn_level   (btn_level),
      .btn_press   (btn_press),
      .btn_release (btn_release),
      .any_press   (any_press)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checkCount = 0;
   int passCount  = 0;

   task automatic checkValue(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, observed, expected);
      end
   endtask

   //---------------------------------------------------------------------------
   // Reference model
   //---------------------------------------------------------------------------
   bit            hist [NB][8];   // raw samples, circular by edge index
   int            edgeIdx;        // edges since the last reset
   logic [NB-1:0] expLevel;
   logic [NB-1:0] expPress;
   logic [NB-1:0] expRelease;
   int            mRun      [NB];
   bit            mHeld     [NB];
   int            mSince    [NB];
   int            mInterval [NB];

   task automatic modelStep(input logic rstS, input logic [NB-1:0] inS,
                            input logic [NB-1:0] enS);
      expPress   = '0;
      expRelease = '0;
      if (rstS) begin
         edgeIdx  = 0;
         expLevel = '0;
         for (int c = 0; c < NB; c++) begin
            mRun[c] = 0; mHeld[c] = 0; mSince[c] = 0; mInterval[c] = RD;
         end
         return;
      end
      for (int c = 0; c < NB; c++) begin
         bit syncV;
         bit rose;
         bit fell;
         // The debouncer sees the sample taken SS edges earlier.
         syncV = (edgeIdx >= SS) ? hist[c][(edgeIdx - SS) % 8] : 1'b0;
         hist[c][edgeIdx % 8] = inS[c];
         rose = 0;
         fell = 0;
         if (syncV != expLevel[c]) begin
            mRun[c]++;
            if (mRun[c] == DC) begin
               mRun[c] = 0;
               expLevel[c] = syncV;
               rose = syncV;
               fell = !syncV;
            end
         end else begin
            mRun[c] = 0;
         end
         if (fell) begin
            expRelease[c] = 1'b1;
            mHeld[c] = 0;
         end else if (rose) begin
            expPress[c]  = 1'b1;
            mHeld[c]     = 1;
            mSince[c]    = 0;
            mInterval[c] = RD;
         end else if (mHeld[c]) begin
            if (enS[c]) begin
               mSince[c]++;
               if (mSince[c] == mInterval[c]) begin
                  expPress[c]  = 1'b1;
                  mSince[c]    = 0;
                  mInterval[c] = RR;
               end
            end else begin
               mSince[c] = 0;
            end
         end
      end
      edgeIdx++;
   endtask

   // One clock: capture the inputs the edge will see, then compare #1 later.
   task automatic tick();
      logic          rstS;
      logic [NB-1:0] inS;
      logic [NB-1:0] enS;
      rstS = reset;
      inS  = btn_in;
      enS  = repeat_en;
      @(posedge clk);
      #1;
      modelStep(rstS, inS, enS);
      checkValue("btn_level",   {29'd0, btn_level},   {29'd0, expLevel});
      checkValue("btn_press",   {29'd0, btn_press},   {29'd0, expPress});
      checkValue("btn_release", {29'd0, btn_release}, {29'd0, expRelease});
      checkValue("any_press",   {31'd0, any_press},   {31'd0, |expPress});
   endtask

   int remain [NB];

   initial begin
      reset     = 1'b1;
      btn_in    = '0;
      repeat_en = '0;
      modelStep(1'b1, '0, '0);

      // Reset with all buttons held: silent during reset, press at edge 6.
      btn_in = 3'b111;
      for (int i = 0; i < 3; i++) begin
         tick();
         checkValue("rst_hold_press", {29'd0, btn_press}, 32'd0);
      end
      reset = 1'b0;
      for (int e = 1; e <= 8; e++) begin
         tick();
         if (e < 6) checkValue("early_level", {29'd0, btn_level}, 32'd0);
         if (e == 6) checkValue("all_press", {29'd0, btn_press}, 32'd7);
         if (e == 7) checkValue("all_level", {29'd0, btn_level}, 32'd7);
      end

      // Release, then a 3-cycle glitch on channel 0 must be rejected.
      btn_in = '0;
      repeat (12) tick();
      btn_in[0] = 1'b1;
      repeat (3) tick();
      btn_in[0] = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         checkValue("glitch_level", {31'd0, btn_level[0]}, 32'd0);
      end

      // Channel 1 held 20 cycles without repeat: one press, one release.
      btn_in[1] = 1'b1;
      repeat (20) tick();
      btn_in[1] = 1'b0;
      repeat (10) tick();

      // Channel 2 repeating; release timed so the fall hits the P+12 tick.
      reset = 1'b1;
      btn_in = 3'b100;
      repeat_en = 3'b100;
      tick();
      reset = 1'b0;
      for (int e = 1; e <= 22; e++) begin
         if (e == 13) btn_in[2] = 1'b0;
         tick();
         if (e == 6 || e == 14) checkValue("rpt_press", {31'd0, btn_press[2]}, 32'd1);
         if (e == 18) begin
            checkValue("coincide_release", {31'd0, btn_release[2]}, 32'd1);
            checkValue("coincide_press",   {31'd0, btn_press[2]},   32'd0);
         end
      end

      // Reset while repeating: no stale pulse, re-press 6 edges later.
      btn_in[2] = 1'b1;
      repeat (25) tick();
      reset = 1'b1;
      tick();
      checkValue("rst_rpt_press", {29'd0, btn_press}, 32'd0);
      reset = 1'b0;
      for (int e = 1; e <= 8; e++) begin
         tick();
         if (e < 6) checkValue("rst_rpt_quiet", {31'd0, btn_press[2]}, 32'd0);
         if (e == 6) checkValue("rst_rpt_repress", {31'd0, btn_press[2]}, 32'd1);
      end

      // Randomized traffic: long holds, short glitches, repeat toggling, resets.
      btn_in = '0;
      for (int c = 0; c < NB; c++) remain[c] = 1;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         for (int c = 0; c < NB; c++) begin
            remain[c]--;
            if (remain[c] <= 0) begin
               btn_in[c] = ~btn_in[c];
               if ($urandom_range(0, 9) < 3) remain[c] = $urandom_range(1, DC - 1);
               else remain[c] = $urandom_range(DC, 40);
            end
            if ($urandom_range(0, 49) == 0) repeat_en[c] = ~repeat_en[c];
         end
         reset = ($urandom_range(0, 399) == 0);
         tick();
      end
      reset = 1'b0;

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
